therm_count_accumulator: RTL

Consumer side of the sorting-network parallel counters: accepts a stream of N-bit thermometer words (sorted-bit outputs of the N-sorter, ones packed toward the MSB), decodes each to a binary count, and accumulates counts over a frame delimited by `in_last`. It is a 2-stage pipeline, decode register then accumulator/output register, with valid/ready handshakes on both sides. It sits directly after the sorter bank and feeds the frame-level statistics logic.

---
 rtl/therm_count_accumulator_if.sv | 25 ++
 rtl/therm_count_accumulator.sv | 130 +++++++++++++
 2 files changed

// File: rtl/therm_count_accumulator_if.sv
// Handshake bundle between the sorter bank (master) and the thermometer count accumulator (slave).
interface therm_count_accumulator_if #(
  parameter int N     = 7,
  parameter int ACC_W = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [N-1:0]     in_therm;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_sum;
  logic             out_sat;
  logic             out_err;

  modport master (
    output in_valid, in_therm, in_last, out_ready,
    input  in_ready, out_valid, out_sum, out_sat, out_err
  );

  modport slave (
    input  in_valid, in_therm, in_last, out_ready,
    output in_ready, out_valid, out_sum, out_sat, out_err
  );
endinterface

// File: rtl/therm_count_accumulator.sv
// Decodes N-bit thermometer words to counts and accumulates them per frame (2-stage pipeline).
// Optional legality checker on out_err is built only when THERM_CHECK_EN is defined.
module therm_count_accumulator #(
  parameter int N     = 7,
  parameter int ACC_W = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  therm_count_accumulator_if.slave bus
);
  localparam int CW = $clog2(N + 1);

  logic             s1_valid_q, s1_valid_d, s1_last_q, s1_last_d;
  logic [CW-1:0]    s1_cnt_q, s1_cnt_d, cnt_in;
  logic [ACC_W-1:0] acc_q, acc_d, out_sum_q, out_sum_d, sum_sat;
  logic [ACC_W:0]   sum_ext;
  logic             sat_f_q, sat_f_d, out_sat_q, out_sat_d, out_valid_q, out_valid_d;
  logic             s1_adv, xfer, ovf;

  // A last word in stage 1 may only move on when the result slot is free or being drained.
  assign s1_adv       = s1_valid_q && (!s1_last_q || !out_valid_q || bus.out_ready);
  assign bus.in_ready = !s1_valid_q || s1_adv;
  assign xfer         = bus.in_valid && bus.in_ready;

  always_comb begin
    cnt_in = '0;
    for (int i = 0; i < N; i++) cnt_in = cnt_in + CW'(bus.in_therm[i]);
  end

  assign sum_ext = {1'b0, acc_q} + {{(ACC_W + 1 - CW){1'b0}}, s1_cnt_q};
  assign ovf     = sum_ext[ACC_W];
  assign sum_sat = ovf ? '1 : sum_ext[ACC_W-1:0];

  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_cnt_d    = s1_cnt_q;
    s1_last_d   = s1_last_q;
    acc_d       = acc_q;
    sat_f_d     = sat_f_q;
    out_sum_d   = out_sum_q;
    out_sat_d   = out_sat_q;
    out_valid_d = out_valid_q && !bus.out_ready;
    if (xfer) begin
      s1_valid_d = 1'b1;
      s1_cnt_d   = cnt_in;
      s1_last_d  = bus.in_last;
    end else if (s1_adv) begin
      s1_valid_d = 1'b0;
    end
    if (s1_adv) begin
      if (s1_last_q) begin
        out_sum_d   = sum_sat;
        out_sat_d   = sat_f_q | ovf;
        out_valid_d = 1'b1;
        acc_d       = '0;
        sat_f_d     = 1'b0;
      end else begin
        acc_d   = sum_sat;
        sat_f_d = sat_f_q | ovf;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_cnt_q    <= '0;
      s1_last_q   <= 1'b0;
      acc_q       <= '0;
      sat_f_q     <= 1'b0;
      out_sum_q   <= '0;
      out_sat_q   <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_cnt_q    <= s1_cnt_d;
      s1_last_q   <= s1_last_d;
      acc_q       <= acc_d;
      sat_f_q     <= sat_f_d;
      out_sum_q   <= out_sum_d;
      out_sat_q   <= out_sat_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_sum   = out_sum_q;
  assign bus.out_sat   = out_sat_q;

`ifdef THERM_CHECK_EN
  logic bad_in, s1_bad_q, s1_bad_d, bad_f_q, bad_f_d, out_err_q, out_err_d;

  // Illegal: a one sitting below a zero breaks the MSB-packed ordering.
  always_comb begin
    bad_in = 1'b0;
    for (int i = 0; i < N - 1; i++)
      if (bus.in_therm[i] && !bus.in_therm[i+1]) bad_in = 1'b1;
  end

  always_comb begin
    s1_bad_d  = xfer ? bad_in : s1_bad_q;
    bad_f_d   = bad_f_q;
    out_err_d = out_err_q;
    if (s1_adv) begin
      if (s1_last_q) begin
        out_err_d = bad_f_q | s1_bad_q;
        bad_f_d   = 1'b0;
      end else begin
        bad_f_d = bad_f_q | s1_bad_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_bad_q  <= 1'b0;
      bad_f_q   <= 1'b0;
      out_err_q <= 1'b0;
    end else begin
      s1_bad_q  <= s1_bad_d;
      bad_f_q   <= bad_f_d;
      out_err_q <= out_err_d;
    end
  end

  assign bus.out_err = out_err_q;
`else
  assign bus.out_err = 1'b0;
`endif
endmodule
